// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared bus types, queue entry and fetch FSM encodings.
// Imported by the fetch queue interface, FIFO and top.
package fetch_queue_pkg;

  typedef enum logic {
    MEMREQ_READ  = 1'b0,
    MEMREQ_WRITE = 1'b1
  } memreq_mode_e;

  typedef struct packed {
    memreq_mode_e mode;
    logic [31:0]  addr;
  } memreq;

  typedef struct packed {
    logic [31:0] data;
  } memresp;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_WAIT = 2'd1,
    FS_HALT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: memory bus request/response plus decode dequeue port.
// master = fetch queue side, slave = bus/decode side.
interface fetch_queue_if #(
  parameter int DEPTH = 4
);
  import fetch_queue_pkg::*;

  localparam int CW = $clog2(DEPTH + 1);

  logic          request_enable;
  memreq         request;
  logic          response_enable;
  memresp        response;
  logic          deq_valid;
  logic          deq_ready;
  logic [31:0]   pc_n;
  logic [31:0]   instr_raw;
  logic          fault;
  logic [CW-1:0] count;

  modport master (
    output request_enable, request,
    output deq_valid, pc_n, instr_raw,
    output fault, count,
    input  response_enable, response,
    input  deq_ready
  );

  modport slave (
    input  request_enable, request,
    input  deq_valid, pc_n, instr_raw,
    input  fault, count,
    output response_enable, response,
    output deq_ready
  );

endinterface

// File: rtl/fetch_queue_fifo.sv
// fetch_queue_fifo: DEPTH-entry FIFO of fetch_entry_t; flush beats push/pop.
// Ports: push/din, pop, flush, head (combinational), count.
module fetch_queue_fifo
  import fetch_queue_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fetch_entry_t  din,
  output fetch_entry_t  head,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_pop;

  assign do_pop = pop && (count != '0);
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push && !flush)
      mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)
        rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: prefetch FSM issuing sequential reads into a FIFO for decode.
// Ports: clk, rst, enabled, redirect/redirect_pc, bus (fetch_queue_if.master).
// Optional: FETCH_ALIGN_CHECK_EN pushes a fault entry for misaligned pc.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PC_STEP  = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enabled,
  input  logic         redirect,
  input  logic [31:0]  redirect_pc,
  fetch_queue_if.master bus
);

  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_e  state, state_nx;
  logic [31:0]   fetch_pc, fetch_pc_nx;
  logic          drop, drop_nx;
  logic          req_en, req_en_nx;
  logic [31:0]   req_addr, req_addr_nx;
  logic          push, pop, flush;
  fetch_entry_t  push_entry, head;
  logic [CW-1:0] count;
  logic          has_space;
  logic          deq_valid;

  assign deq_valid = (count != '0);
  assign has_space = (count < CW'(DEPTH));
  assign pop       = deq_valid && bus.deq_ready;

  fetch_queue_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (push_entry),
    .head  (head),
    .count (count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FS_IDLE;
      fetch_pc <= RESET_PC;
      drop     <= 1'b0;
      req_en   <= 1'b0;
      req_addr <= '0;
    end else begin
      state    <= state_nx;
      fetch_pc <= fetch_pc_nx;
      drop     <= drop_nx;
      req_en   <= req_en_nx;
      req_addr <= req_addr_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    fetch_pc_nx = fetch_pc;
    drop_nx     = drop;
    req_en_nx   = 1'b0;
    req_addr_nx = req_addr;
    push        = 1'b0;
    flush       = 1'b0;
    push_entry  = '{pc: fetch_pc,
                    instr: bus.response.data,
                    fault: 1'b0};
    if (redirect) begin
      flush       = 1'b1;
      fetch_pc_nx = redirect_pc;
      // still owed a response: swallow it when it shows up
      if (state == FS_WAIT && !bus.response_enable) begin
        drop_nx = 1'b1;
      end else begin
        drop_nx  = 1'b0;
        state_nx = FS_IDLE;
      end
    end else begin
      unique case (state)
        FS_IDLE: begin
          if (enabled && has_space) begin
`ifdef FETCH_ALIGN_CHECK_EN
            if (fetch_pc[1:0] != 2'b00) begin
              push             = 1'b1;
              push_entry.instr = '0;
              push_entry.fault = 1'b1;
              state_nx         = FS_HALT;
            end else
`endif
            begin
              req_en_nx   = 1'b1;
              req_addr_nx = fetch_pc;
              state_nx    = FS_WAIT;
            end
          end
        end
        FS_WAIT: begin
          if (bus.response_enable) begin
            if (!drop) begin
              push        = 1'b1;
              fetch_pc_nx = fetch_pc + 32'(PC_STEP);
            end
            drop_nx  = 1'b0;
            state_nx = FS_IDLE;
          end
        end
`ifdef FETCH_ALIGN_CHECK_EN
        FS_HALT: state_nx = FS_HALT;
`endif
        default: state_nx = FS_IDLE;
      endcase
    end
  end

  assign bus.request_enable = req_en;
  assign bus.request        = '{mode: MEMREQ_READ,
                                addr: req_addr};
  assign bus.deq_valid      = deq_valid;
  assign bus.pc_n           = head.pc;
  assign bus.instr_raw      = head.instr;
  assign bus.count          = count;

`ifdef FETCH_ALIGN_CHECK_EN
  assign bus.fault = head.fault;
`else
  logic unused_fault;
  assign unused_fault = head.fault;
  assign bus.fault    = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: scoreboard bench for fetch_queue with a fixed-latency bus.
// Expected entries are queued on response and checked on dequeue.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam int          LAT      = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enabled = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;

  fetch_queue_if #(.DEPTH(DEPTH)) bus ();

  fetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC),
    .PC_STEP  (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enabled     (enabled),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int vec = 0;
  int bad = 0;

  fetch_entry_t exp_q[$];
  logic [31:0]  m_pc;
  logic [31:0]  last_addr;
  bit           m_wait, m_drop, m_halt;
  int           cd, resp_n, strobes;

  task automatic model_reset();
    exp_q.delete();
    m_pc    = RESET_PC;
    m_wait  = 0;
    m_drop  = 0;
    m_halt  = 0;
    cd      = 0;
    resp_n  = 0;
    strobes = 0;
    last_addr = 'x;
  endtask

  // one clock: scoreboard pop check, model update, bus monitor/responder
  task automatic step();
    bit           red_now, resp_now, pop_now;
    int           sz0;
    fetch_entry_t e;
    red_now  = redirect;
    resp_now = bus.response_enable;
    pop_now  = bus.deq_ready && bus.deq_valid;
    sz0      = exp_q.size();
    if (pop_now && !red_now) begin
      vec++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL pop_empty pc=%h want no entry", bus.pc_n);
      end else begin
        e = exp_q.pop_front();
        if (bus.pc_n !== e.pc || bus.instr_raw !== e.instr ||
            bus.fault !== e.fault) begin
          bad++;
          $display("FAIL pop got %h/%h/%b want %h/%h/%b",
                   bus.pc_n, bus.instr_raw, bus.fault,
                   e.pc, e.instr, e.fault);
        end
      end
    end
    if (red_now) begin
      exp_q.delete();
      m_pc   = redirect_pc;
      m_drop = m_wait && !resp_now;
      m_wait = m_wait && !resp_now;
      m_halt = 0;
    end else begin
      if (m_wait && resp_now) begin
        if (!m_drop) begin
          exp_q.push_back('{pc: m_pc,
                            instr: bus.response.data,
                            fault: 1'b0});
          m_pc = m_pc + 32'd4;
        end
        m_drop = 0;
        m_wait = 0;
      end
`ifdef FETCH_ALIGN_CHECK_EN
      else if (!m_wait && !m_halt && enabled &&
               sz0 < DEPTH && m_pc[1:0] != 2'b00) begin
        exp_q.push_back('{pc: m_pc, instr: 32'h0,
                          fault: 1'b1});
        m_halt = 1;
      end
`endif
    end
    @(posedge clk);
    #1;
    redirect = 1'b0;
    bus.response_enable = 1'b0;
    vec++;
    if (bus.count !== exp_q.size() ||
        bus.deq_valid !== (exp_q.size() != 0)) begin
      bad++;
      $display("FAIL count got %0d/%b want %0d",
               bus.count, bus.deq_valid, exp_q.size());
    end
    if (bus.request_enable === 1'b1) begin
      vec++;
      if (bus.request.addr !== m_pc || m_wait ||
          bus.request.mode !== MEMREQ_READ) begin
        bad++;
        $display("FAIL strobe addr=%h busy=%b want %h",
                 bus.request.addr, m_wait, m_pc);
      end
      last_addr = bus.request.addr;
      m_wait    = 1;
      cd        = LAT;
      strobes++;
    end else if (m_wait && cd > 0) begin
      cd--;
      if (cd == 0) begin
        bus.response_enable = 1'b1;
        bus.response.data   = 32'h13 + 32'(resp_n);
        resp_n++;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    enabled = 1'b0;
    redirect = 1'b0;
    bus.response_enable = 1'b0;
    bus.deq_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    vec++;
    if (bus.request_enable !== 1'b0) begin
      bad++; $display("FAIL rst_req got %b want 0", bus.request_enable);
    end
    vec++;
    if (bus.count !== '0) begin
      bad++; $display("FAIL rst_count got %0d want 0", bus.count);
    end
    vec++;
    if (bus.deq_valid !== 1'b0) begin
      bad++; $display("FAIL rst_valid got %b want 0", bus.deq_valid);
    end
    vec++;
    if (bus.request.addr !== 32'h0) begin
      bad++; $display("FAIL rst_addr got %h want 0", bus.request.addr);
    end
    vec++;
    if (bus.request.mode !== MEMREQ_READ) begin
      bad++; $display("FAIL rst_mode got %b want READ", bus.request.mode);
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_fill_drain();
    do_reset();
    enabled = 1'b1;
    for (int i = 0; i < 40; i++) step();
    vec++;
    if (strobes != 4) begin
      bad++; $display("FAIL fill_strobes got %0d want 4", strobes);
    end
    vec++;
    if (bus.count !== 3'd4) begin
      bad++; $display("FAIL fill_count got %0d want 4", bus.count);
    end
    enabled = 1'b0;
    bus.deq_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    bus.deq_ready = 1'b0;
    vec++;
    if (exp_q.size() != 0 || bus.count !== '0) begin
      bad++;
      $display("FAIL drain left %0d want 0", bus.count);
    end
  endtask

  task automatic test_redirect_inflight();
    do_reset();
    enabled = 1'b1;
    for (int i = 0; i < 40 && strobes < 3; i++) step();
    vec++;
    if (strobes != 3 || last_addr !== 32'h8) begin
      bad++; $display("FAIL rd_setup addr=%h want 8", last_addr);
    end
    redirect = 1'b1;
    redirect_pc = 32'h100;
    step();
    vec++;
    if (bus.count !== '0) begin
      bad++; $display("FAIL rd_flush got %0d want 0", bus.count);
    end
    for (int i = 0; i < 40 && strobes < 4; i++) step();
    vec++;
    if (strobes != 4 || last_addr !== 32'h100) begin
      bad++; $display("FAIL rd_addr got %h want 100", last_addr);
    end
    for (int i = 0; i < 20 && bus.deq_valid !== 1'b1; i++) step();
    vec++;
    if (bus.pc_n !== 32'h100 || bus.instr_raw !== 32'h16) begin
      bad++;
      $display("FAIL rd_head got %h/%h want 100/16",
               bus.pc_n, bus.instr_raw);
    end
  endtask

  task automatic test_redirect_collide();
    do_reset();
    enabled = 1'b1;
    for (int i = 0; i < 40 &&
         !(strobes == 3 && bus.response_enable); i++) step();
    vec++;
    if (bus.count !== 3'd2 || bus.response_enable !== 1'b1) begin
      bad++; $display("FAIL col_setup got %0d want 2", bus.count);
    end
    redirect = 1'b1;
    redirect_pc = 32'h40;
    bus.deq_ready = 1'b1;
    step();
    bus.deq_ready = 1'b0;
    vec++;
    if (bus.count !== '0 || bus.deq_valid !== 1'b0) begin
      bad++; $display("FAIL col_flush got %0d want 0", bus.count);
    end
    for (int i = 0; i < 40 && strobes < 4; i++) step();
    vec++;
    if (strobes != 4 || last_addr !== 32'h40) begin
      bad++; $display("FAIL col_addr got %h want 40", last_addr);
    end
    do_reset();
    enabled = 1'b1;
    for (int i = 0; i < 40 &&
         !(strobes == 3 && bus.response_enable); i++) step();
    bus.deq_ready = 1'b1;
    step();
    bus.deq_ready = 1'b0;
    vec++;
    if (bus.count !== 3'd2) begin
      bad++; $display("FAIL pushpop got %0d want 2", bus.count);
    end
  endtask

  task automatic test_wrap_and_reset();
    do_reset();
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    enabled = 1'b1;
    for (int i = 0; i < 40 && strobes < 2; i++) step();
    vec++;
    if (strobes != 2 || last_addr !== 32'h0) begin
      bad++; $display("FAIL wrap got %h want 0", last_addr);
    end
    for (int i = 0; i < 20 && bus.request_enable !== 1'b1; i++) step();
    #2;
    rst = 1'b1;
    #1;
    vec++;
    if (bus.request_enable !== 1'b0 || bus.count !== '0) begin
      bad++;
      $display("FAIL async_rst got %b/%0d want 0/0",
               bus.request_enable, bus.count);
    end
    enabled = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    bus.response_enable = 1'b1;
    bus.response.data = 32'hDEAD_BEEF;
    step();
    vec++;
    if (bus.count !== '0 || bus.deq_valid !== 1'b0) begin
      bad++; $display("FAIL stale_resp got %0d want 0", bus.count);
    end
    enabled = 1'b1;
    for (int i = 0; i < 20 && strobes < 1; i++) step();
    vec++;
    if (strobes != 1 || last_addr !== RESET_PC) begin
      bad++; $display("FAIL post_rst got %h want %h", last_addr, RESET_PC);
    end
  endtask

  task automatic test_enable_drop();
    do_reset();
    enabled = 1'b1;
    for (int i = 0; i < 20 && strobes < 1; i++) step();
    enabled = 1'b0;
    for (int i = 0; i < 12; i++) step();
    vec++;
    if (strobes != 1) begin
      bad++; $display("FAIL en_strobes got %0d want 1", strobes);
    end
    vec++;
    if (bus.count !== 3'd1) begin
      bad++; $display("FAIL en_count got %0d want 1", bus.count);
    end
    enabled = 1'b1;
    for (int i = 0; i < 20 && strobes < 2; i++) step();
    vec++;
    if (strobes != 2 || last_addr !== 32'h4) begin
      bad++; $display("FAIL en_resume got %h want 4", last_addr);
    end
  endtask

  task automatic test_align();
    do_reset();
    redirect = 1'b1;
    redirect_pc = 32'h102;
    step();
    enabled = 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
    for (int i = 0; i < 10; i++) step();
    vec++;
    if (strobes != 0) begin
      bad++; $display("FAIL al_strobe got %0d want 0", strobes);
    end
    vec++;
    if (bus.count !== 3'd1 || bus.pc_n !== 32'h102 ||
        bus.fault !== 1'b1 || bus.instr_raw !== 32'h0) begin
      bad++;
      $display("FAIL al_entry got %h/%h/%b want 102/0/1",
               bus.pc_n, bus.instr_raw, bus.fault);
    end
    redirect = 1'b1;
    redirect_pc = 32'h200;
    step();
    for (int i = 0; i < 20 && strobes < 1; i++) step();
    vec++;
    if (strobes != 1 || last_addr !== 32'h200) begin
      bad++; $display("FAIL al_resume got %h want 200", last_addr);
    end
`else
    for (int i = 0; i < 20 && strobes < 1; i++) step();
    vec++;
    if (strobes != 1 || last_addr !== 32'h102) begin
      bad++; $display("FAIL al_addr got %h want 102", last_addr);
    end
    for (int i = 0; i < 20 && bus.deq_valid !== 1'b1; i++) step();
    vec++;
    if (bus.pc_n !== 32'h102 || bus.fault !== 1'b0 ||
        bus.instr_raw !== 32'h13) begin
      bad++;
      $display("FAIL al_entry got %h/%h/%b want 102/13/0",
               bus.pc_n, bus.instr_raw, bus.fault);
    end
`endif
  endtask

  initial begin
    bus.response_enable = 1'b0;
    bus.response = '0;
    bus.deq_ready = 1'b0;
    model_reset();
    test_reset();
    test_fill_drain();
    test_redirect_inflight();
    test_redirect_collide();
    test_wrap_and_reset();
    test_enable_drop();
    test_align();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout after 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
